// File: rtl/sad_stim_gen_pkg.sv
// Shared types, LFSR geometry and step function for the SAD stimulus generator.
package sad_pkg;

  localparam int LFSR_W = 48;

  // Feedback taps of the 48-bit Fibonacci LFSR (x^48 + x^47 + x^21 + x^20 + 1)
  localparam int TAP_A = 47;
  localparam int TAP_B = 46;
  localparam int TAP_C = 20;
  localparam int TAP_D = 19;

  localparam logic [LFSR_W-1:0] LFSR_ZERO_SUB = 48'h1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WARMUP,
    ST_RUN,
    ST_DONE
  } state_t;

  // One operand vector; f is the most significant byte of the LFSR state.
  typedef struct packed {
    logic [7:0] f;
    logic [7:0] e;
    logic [7:0] d;
    logic [7:0] c;
    logic [7:0] b;
    logic [7:0] a;
  } vec_t;

  function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] s);
    return {s[LFSR_W-2:0], s[TAP_A] ^ s[TAP_B] ^ s[TAP_C] ^ s[TAP_D]};
  endfunction

endpackage

// File: rtl/sad_stim_gen_if.sv
// Control and operand bundle between the stimulus generator (master) and its sad/logger consumer (slave).
// The stall signal only exists when SAD_STIM_STALL_EN is defined.
interface sad_stim_gen_if;

  logic        start;
  logic [47:0] seed;
`ifdef SAD_STIM_STALL_EN
  logic        stall;
`endif
  logic [7:0]  a;
  logic [7:0]  b;
  logic [7:0]  c;
  logic [7:0]  d;
  logic [7:0]  e;
  logic [7:0]  f;
  logic        valid;
  logic        capture;
  logic [15:0] vec_idx;
  logic        done;

`ifdef SAD_STIM_STALL_EN
  modport master (
    input  start, seed, stall,
    output a, b, c, d, e, f, valid, capture, vec_idx, done
  );

  modport slave (
    output start, seed, stall,
    input  a, b, c, d, e, f, valid, capture, vec_idx, done
  );
`else
  modport master (
    input  start, seed,
    output a, b, c, d, e, f, valid, capture, vec_idx, done
  );

  modport slave (
    output start, seed,
    input  a, b, c, d, e, f, valid, capture, vec_idx, done
  );
`endif

endinterface

// File: rtl/sad_stim_gen_lfsr.sv
// 48-bit Fibonacci LFSR: synchronous load has priority, otherwise one step per enable.
// Load value is expected non-zero; the caller substitutes the all-zero seed.
module sad_lfsr48
  import sad_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [LFSR_W-1:0] load_val,
  input  logic              en,
  output logic [LFSR_W-1:0] q
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q <= LFSR_ZERO_SUB;
    end else if (load) begin
      q <= load_val;
    end else if (en) begin
      q <= lfsr_step(q);
    end
  end

endmodule

// File: rtl/sad_stim_gen.sv
// Seeded LFSR vector transmitter for sad: warm-up, NUM_VECTORS back-to-back vectors, capture delayed by SAD_LATENCY.
// All outputs registered; optional SAD_STIM_STALL_EN adds a stall input that pauses RUN with valid low.
module sad_stim_gen
  import sad_pkg::*;
#(
  parameter int unsigned NUM_VECTORS   = 1000,
  parameter int unsigned WARMUP_CYCLES = 5,
  parameter int unsigned SAD_LATENCY   = 1
) (
  input  logic           clk,
  input  logic           rst,
  sad_stim_gen_if.master io
);

  localparam logic [15:0] NUM_V     = 16'(NUM_VECTORS);
  localparam logic [15:0] WARM_LAST = (WARMUP_CYCLES <= 1) ? 16'd0 : 16'(WARMUP_CYCLES - 1);

  state_t             state;
  state_t             state_nx;

  logic [15:0]        warm_q;
  logic [15:0]        warm_nx;
  logic [15:0]        sent_q;
  logic [15:0]        sent_nx;
  logic [15:0]        idx_q;
  logic [15:0]        idx_nx;
  vec_t               vec_q;
  vec_t               vec_nx;
  logic               valid_q;
  logic               valid_nx;
  logic               done_q;
  logic               done_nx;
  logic [SAD_LATENCY-1:0] cap_sr;

  logic               accept;
  logic               warm_last;
  logic               all_sent;
  logic               stall_run;
  logic               emit;
  logic [LFSR_W-1:0]  lfsr_q;
  logic [LFSR_W-1:0]  lfsr_seed;

`ifdef SAD_STIM_STALL_EN
  assign stall_run = io.stall;
`else
  assign stall_run = 1'b0;
`endif

  assign accept    = io.start && ((state == ST_IDLE) || (state == ST_DONE));
  assign warm_last = (warm_q == WARM_LAST);
  assign all_sent  = (sent_q == NUM_V);
  assign lfsr_seed = (io.seed == '0) ? LFSR_ZERO_SUB : io.seed;

  // A vector is launched on the edge leaving warm-up and on every unstalled RUN edge still owing vectors.
  assign emit = ((state == ST_WARMUP) && warm_last && (NUM_V != 16'd0)) ||
                ((state == ST_RUN) && !all_sent && !stall_run);

  sad_lfsr48 u_lfsr (
    .clk      (clk),
    .rst      (rst),
    .load     (accept),
    .load_val (lfsr_seed),
    .en       (emit),
    .q        (lfsr_q)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE, ST_DONE: begin
        if (io.start) state_nx = ST_WARMUP;
      end
      ST_WARMUP: begin
        if (warm_last) state_nx = (NUM_V == 16'd0) ? ST_DONE : ST_RUN;
      end
      ST_RUN: begin
        if (all_sent) state_nx = ST_DONE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  always_comb begin
    warm_nx  = warm_q;
    sent_nx  = sent_q;
    idx_nx   = idx_q;
    vec_nx   = vec_q;
    valid_nx = 1'b0;
    done_nx  = done_q;
    if (accept) begin
      warm_nx = '0;
      sent_nx = '0;
      idx_nx  = '0;
      vec_nx  = '0;
      done_nx = 1'b0;
    end else if (emit) begin
      vec_nx   = vec_t'(lfsr_q);
      valid_nx = 1'b1;
      idx_nx   = sent_q;
      sent_nx  = sent_q + 16'd1;
    end else if (state_nx == ST_DONE) begin
      vec_nx  = '0;
      idx_nx  = NUM_V;
      done_nx = 1'b1;
    end else if (state == ST_WARMUP) begin
      warm_nx = warm_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      warm_q  <= '0;
      sent_q  <= '0;
      idx_q   <= '0;
      vec_q   <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      warm_q  <= warm_nx;
      sent_q  <= sent_nx;
      idx_q   <= idx_nx;
      vec_q   <= vec_nx;
      valid_q <= valid_nx;
      done_q  <= done_nx;
    end
  end

  // Capture pipe is never cleared by start so the tail of the previous run still drains.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cap_sr <= '0;
    end else begin
      for (int i = SAD_LATENCY - 1; i > 0; i--) begin
        cap_sr[i] <= cap_sr[i-1];
      end
      cap_sr[0] <= valid_q;
    end
  end

  assign io.a       = vec_q.a;
  assign io.b       = vec_q.b;
  assign io.c       = vec_q.c;
  assign io.d       = vec_q.d;
  assign io.e       = vec_q.e;
  assign io.f       = vec_q.f;
  assign io.valid   = valid_q;
  assign io.capture = cap_sr[SAD_LATENCY-1];
  assign io.vec_idx = idx_q;
  assign io.done    = done_q;

endmodule

// File: tb/tb_sad_stim_gen.sv
// Directed bench for sad_stim_gen: three parameterisations share one clock and reset.
// Stall checks are compiled only when SAD_STIM_STALL_EN is defined.
module tb_sad_stim_gen;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_chk  = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  sad_stim_gen_if if_main ();
  sad_stim_gen_if if_zero ();
  sad_stim_gen_if if_lat ();

  sad_stim_gen #(.NUM_VECTORS(6), .WARMUP_CYCLES(5), .SAD_LATENCY(1)) u_main (
    .clk (clk), .rst (rst), .io (if_main)
  );
  sad_stim_gen #(.NUM_VECTORS(0), .WARMUP_CYCLES(5), .SAD_LATENCY(1)) u_zero (
    .clk (clk), .rst (rst), .io (if_zero)
  );
  sad_stim_gen #(.NUM_VECTORS(4), .WARMUP_CYCLES(2), .SAD_LATENCY(3)) u_lat (
    .clk (clk), .rst (rst), .io (if_lat)
  );

  logic [47:0] main_vec;
  logic [47:0] lat_vec;
  assign main_vec = {if_main.f, if_main.e, if_main.d, if_main.c, if_main.b, if_main.a};
  assign lat_vec  = {if_lat.f, if_lat.e, if_lat.d, if_lat.c, if_lat.b, if_lat.a};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic start_main(input logic [47:0] s);
    if_main.seed  = s;
    if_main.start = 1'b1;
    tick();
    if_main.start = 1'b0;
  endtask

  // Seed 1 gives a walking one for the first 19 steps, so vector k is 1<<k.
  task automatic run_walking_one(input bit poke_start);
    for (int c = 1; c <= 5; c++) begin
      chk("warm_valid", 64'(if_main.valid), 64'(0));
      chk("warm_vec", 64'(main_vec), 64'(0));
      tick();
    end
    for (int k = 0; k < 6; k++) begin
      chk("run_valid", 64'(if_main.valid), 64'(1));
      chk("run_vec", 64'(main_vec), 64'(48'(1) << k));
      chk("run_idx", 64'(if_main.vec_idx), 64'(k));
      chk("run_done", 64'(if_main.done), 64'(0));
      chk("run_capture", 64'(if_main.capture), 64'((k > 0) ? 1 : 0));
      if (poke_start && k == 2) begin
        if_main.seed  = 48'h0000_00AB_CDEF;
        if_main.start = 1'b1;
      end
      tick();
      if_main.start = 1'b0;
    end
    chk("end_done", 64'(if_main.done), 64'(1));
    chk("end_valid", 64'(if_main.valid), 64'(0));
    chk("end_vec", 64'(main_vec), 64'(0));
    chk("end_idx", 64'(if_main.vec_idx), 64'(6));
    chk("end_capture", 64'(if_main.capture), 64'(1));
    tick();
    chk("drained_capture", 64'(if_main.capture), 64'(0));
    chk("held_done", 64'(if_main.done), 64'(1));
  endtask

  initial begin
    if_main.start = 1'b0; if_main.seed = '0;
    if_zero.start = 1'b0; if_zero.seed = '0;
    if_lat.start  = 1'b0; if_lat.seed  = '0;
`ifdef SAD_STIM_STALL_EN
    if_main.stall = 1'b0; if_zero.stall = 1'b0; if_lat.stall = 1'b0;
`endif

    // Reset values
    #12;
    chk("rst_valid", 64'(if_main.valid), 64'(0));
    chk("rst_capture", 64'(if_main.capture), 64'(0));
    chk("rst_idx", 64'(if_main.vec_idx), 64'(0));
    chk("rst_done", 64'(if_main.done), 64'(0));
    chk("rst_vec", 64'(main_vec), 64'(0));
    rst = 1'b1;
    tick();
    tick();
    chk("idle_valid", 64'(if_main.valid), 64'(0));

    // Basic walking-one run with an ignored start in the middle
    start_main(48'h1);
    run_walking_one(1'b1);

    // Zero seed restarts from DONE and behaves exactly like seed 1
    start_main(48'h0);
    chk("restart_done_cleared", 64'(if_main.done), 64'(0));
    chk("restart_idx_cleared", 64'(if_main.vec_idx), 64'(0));
    run_walking_one(1'b0);

    // Mid-run reset, then restart with a seed that exercises the high taps
    start_main(48'hC000_0000_0000);
    for (int c = 1; c <= 5; c++) tick();
    chk("hi_v0", 64'(main_vec), 64'(48'hC000_0000_0000));
    tick();
    chk("hi_v1", 64'(main_vec), 64'(48'h8000_0000_0000));
    rst = 1'b0;
    #1;
    chk("mid_rst_valid", 64'(if_main.valid), 64'(0));
    chk("mid_rst_vec", 64'(main_vec), 64'(0));
    tick();
    chk("mid_rst_idx", 64'(if_main.vec_idx), 64'(0));
    chk("mid_rst_capture", 64'(if_main.capture), 64'(0));
    chk("mid_rst_done", 64'(if_main.done), 64'(0));
    rst = 1'b1;
    tick();
    chk("post_rst_idle_valid", 64'(if_main.valid), 64'(0));
    start_main(48'hC000_0000_0000);
    for (int c = 1; c <= 5; c++) tick();
    chk("re_v0", 64'(main_vec), 64'(48'hC000_0000_0000));
    chk("re_idx0", 64'(if_main.vec_idx), 64'(0));
    tick();
    chk("re_v1", 64'(main_vec), 64'(48'h8000_0000_0000));
    tick();
    chk("re_v2", 64'(main_vec), 64'(48'h0000_0000_0001));
    chk("re_idx2", 64'(if_main.vec_idx), 64'(2));
    for (int c = 0; c < 4; c++) tick();
    chk("re_done", 64'(if_main.done), 64'(1));

    // Seed on the low taps: feedback bit appears on the third vector
    start_main(48'h0000_0018_0000);
    for (int c = 1; c <= 5; c++) tick();
    chk("lo_v0", 64'(main_vec), 64'(48'h0000_0018_0000));
    tick();
    chk("lo_v1", 64'(main_vec), 64'(48'h0000_0030_0000));
    tick();
    chk("lo_v2", 64'(main_vec), 64'(48'h0000_0060_0001));
    for (int c = 0; c < 4; c++) tick();
    chk("lo_done", 64'(if_main.done), 64'(1));

    // NUM_VECTORS = 0: no valid, no capture, done at cycle WARMUP_CYCLES+1
    if_zero.seed  = 48'h1;
    if_zero.start = 1'b1;
    tick();
    if_zero.start = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      chk("zero_valid", 64'(if_zero.valid), 64'(0));
      chk("zero_capture", 64'(if_zero.capture), 64'(0));
      chk("zero_done", 64'(if_zero.done), 64'((c >= 6) ? 1 : 0));
      tick();
    end
    chk("zero_idx", 64'(if_zero.vec_idx), 64'(0));

    // SAD_LATENCY = 3, NUM_VECTORS = 4, WARMUP_CYCLES = 2: valid 3..6, capture 6..9, done from 7
    if_lat.seed  = 48'h1;
    if_lat.start = 1'b1;
    tick();
    if_lat.start = 1'b0;
    for (int c = 1; c <= 11; c++) begin
      chk("lat_valid", 64'(if_lat.valid), 64'((c >= 3 && c <= 6) ? 1 : 0));
      chk("lat_capture", 64'(if_lat.capture), 64'((c >= 6 && c <= 9) ? 1 : 0));
      chk("lat_done", 64'(if_lat.done), 64'((c >= 7) ? 1 : 0));
      if (c >= 3 && c <= 6) chk("lat_vec", 64'(lat_vec), 64'(48'(1) << (c - 3)));
      tick();
    end

`ifdef SAD_STIM_STALL_EN
    // Two stall cycles after vector 1, with a start pulse that must be ignored
    start_main(48'h1);
    for (int c = 1; c <= 5; c++) tick();
    chk("st_v0", 64'(main_vec), 64'(48'h1));
    tick();
    chk("st_v1", 64'(main_vec), 64'(48'h2));
    if_main.stall = 1'b1;
    if_main.start = 1'b1;
    if_main.seed  = 48'h0000_0000_0F0F;
    tick();
    if_main.start = 1'b0;
    chk("st_hold_valid0", 64'(if_main.valid), 64'(0));
    chk("st_hold_vec0", 64'(main_vec), 64'(48'h2));
    chk("st_hold_idx0", 64'(if_main.vec_idx), 64'(1));
    tick();
    chk("st_hold_valid1", 64'(if_main.valid), 64'(0));
    chk("st_hold_vec1", 64'(main_vec), 64'(48'h2));
    if_main.stall = 1'b0;
    tick();
    for (int k = 2; k < 6; k++) begin
      chk("st_valid", 64'(if_main.valid), 64'(1));
      chk("st_vec", 64'(main_vec), 64'(48'(1) << k));
      chk("st_idx", 64'(if_main.vec_idx), 64'(k));
      tick();
    end
    chk("st_done", 64'(if_main.done), 64'(1));
    chk("st_done_idx", 64'(if_main.vec_idx), 64'(6));
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
